// File: rtl/surf_cmd_rx.sv
// surf_cmd_rx - SURF-side receiver for the serial CMD line driven by the TURF.
//
// Frame (MSB first, one bit per clk_i):
//   start(1) | buffer number (BUF_BITS) | event ID (EVID_BITS) | parity | stop(0)
// Parity is odd over buffer + event ID + parity bit.
//
// Ports:
//   clk_i         SURF clock forwarded from the TURF; cmd_i sampled on rising edge
//   rst_i         synchronous active-high reset
//   cmd_i         serial CMD line, idles low
//   enable_i      gates evt_valid_o only; frames are always decoded
//   evt_valid_o   one-cycle strobe for a good frame
//   buf_o         buffer number of the last good frame
//   evid_o        event ID of the last good frame
//   parity_err_o  one-cycle strobe on parity failure
//   frame_err_o   one-cycle strobe when the stop bit is not low
//   busy_o        high while the receiver is outside IDLE
//   good_cnt_o    saturating good-frame counter (SURF_CMD_RX_COUNTERS_EN only)
//   err_cnt_o     saturating errored-frame counter (SURF_CMD_RX_COUNTERS_EN only)
//
// Optional feature: define SURF_CMD_RX_COUNTERS_EN to build the status
// counters; otherwise good_cnt_o and err_cnt_o are tied to zero.

module surf_cmd_rx #(
  parameter int BUF_BITS  = 2,
  parameter int EVID_BITS = 32,
  parameter int CNT_BITS  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cmd_i,
  input  logic                 enable_i,
  output logic                 evt_valid_o,
  output logic [BUF_BITS-1:0]  buf_o,
  output logic [EVID_BITS-1:0] evid_o,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 busy_o,
  output logic [CNT_BITS-1:0]  good_cnt_o,
  output logic [CNT_BITS-1:0]  err_cnt_o
);

  localparam int DATA_BITS   = BUF_BITS + EVID_BITS;
  localparam int BITCNT_BITS = $clog2(DATA_BITS + 1);
  localparam logic [BITCNT_BITS-1:0] LAST_BIT = BITCNT_BITS'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SHIFT     = 3'd1,
    ST_PARITY    = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } state_t;

  // Odd parity: the XOR of data and parity bit must be one.
  function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] data,
                                         input logic                 par);
    odd_parity_ok = ((^{data, par}) == 1'b1);
  endfunction

  logic                   cmd_q_r;
  state_t                 state_r;
  state_t                 state_s;
  logic [DATA_BITS-1:0]   shift_r;
  logic [BITCNT_BITS-1:0] bit_cnt_r;
  logic                   parity_r;
  logic                   good_frame_s;
  logic                   parity_bad_s;
  logic                   stop_bad_s;
  logic                   evt_valid_r;
  logic                   parity_err_r;
  logic                   frame_err_r;
  logic                   busy_r;
  logic [BUF_BITS-1:0]    buf_r;
  logic [EVID_BITS-1:0]   evid_r;

  // Input flop (IOB); everything downstream works on cmd_q_r only.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cmd_q_r <= 1'b0;
    end else begin
      cmd_q_r <= cmd_i;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic and frame evaluation in STOP.
  always_comb begin
    state_s      = state_r;
    good_frame_s = 1'b0;
    parity_bad_s = 1'b0;
    stop_bad_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cmd_q_r) state_s = ST_SHIFT;
        else         state_s = ST_IDLE;
      end
      ST_SHIFT: begin
        if (bit_cnt_r == LAST_BIT) state_s = ST_PARITY;
        else                       state_s = ST_SHIFT;
      end
      ST_PARITY: begin
        state_s = ST_STOP;
      end
      ST_STOP: begin
        stop_bad_s   = cmd_q_r;
        parity_bad_s = !odd_parity_ok(shift_r, parity_r);
        good_frame_s = !cmd_q_r && odd_parity_ok(shift_r, parity_r);
        // A high stop bit may be a stuck line: wait for it to drop before
        // accepting another start bit.
        if (cmd_q_r) state_s = ST_WAIT_IDLE;
        else         state_s = ST_IDLE;
      end
      ST_WAIT_IDLE: begin
        if (cmd_q_r) state_s = ST_WAIT_IDLE;
        else         state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Deserialiser: shift register, bit counter and latched parity bit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_r   <= {DATA_BITS{1'b0}};
      bit_cnt_r <= {BITCNT_BITS{1'b0}};
      parity_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          bit_cnt_r <= {BITCNT_BITS{1'b0}};
        end
        ST_SHIFT: begin
          shift_r   <= {shift_r[DATA_BITS-2:0], cmd_q_r};
          bit_cnt_r <= bit_cnt_r + BITCNT_BITS'(1);
        end
        ST_PARITY: begin
          parity_r <= cmd_q_r;
        end
        default: begin
          shift_r   <= shift_r;
          bit_cnt_r <= bit_cnt_r;
          parity_r  <= parity_r;
        end
      endcase
    end
  end

  // Output registers; STOP lasts one cycle so every strobe is single-cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      evt_valid_r  <= 1'b0;
      parity_err_r <= 1'b0;
      frame_err_r  <= 1'b0;
      busy_r       <= 1'b0;
      buf_r        <= {BUF_BITS{1'b0}};
      evid_r       <= {EVID_BITS{1'b0}};
    end else begin
      evt_valid_r  <= good_frame_s & enable_i;
      parity_err_r <= parity_bad_s;
      frame_err_r  <= stop_bad_s;
      busy_r       <= (state_s != ST_IDLE);
      if (good_frame_s) begin
        buf_r  <= shift_r[DATA_BITS-1 -: BUF_BITS];
        evid_r <= shift_r[EVID_BITS-1:0];
      end else begin
        buf_r  <= buf_r;
        evid_r <= evid_r;
      end
    end
  end

  assign evt_valid_o  = evt_valid_r;
  assign parity_err_o = parity_err_r;
  assign frame_err_o  = frame_err_r;
  assign busy_o       = busy_r;
  assign buf_o        = buf_r;
  assign evid_o       = evid_r;

`ifdef SURF_CMD_RX_COUNTERS_EN
  logic [CNT_BITS-1:0] good_cnt_r;
  logic [CNT_BITS-1:0] err_cnt_r;

  // Saturating status counters; an errored frame counts once even if both
  // error strobes fire.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      good_cnt_r <= {CNT_BITS{1'b0}};
      err_cnt_r  <= {CNT_BITS{1'b0}};
    end else begin
      if (good_frame_s && (good_cnt_r != {CNT_BITS{1'b1}})) begin
        good_cnt_r <= good_cnt_r + CNT_BITS'(1);
      end else begin
        good_cnt_r <= good_cnt_r;
      end
      if ((parity_bad_s || stop_bad_s) && (err_cnt_r != {CNT_BITS{1'b1}})) begin
        err_cnt_r <= err_cnt_r + CNT_BITS'(1);
      end else begin
        err_cnt_r <= err_cnt_r;
      end
    end
  end

  assign good_cnt_o = good_cnt_r;
  assign err_cnt_o  = err_cnt_r;
`else
  assign good_cnt_o = {CNT_BITS{1'b0}};
  assign err_cnt_o  = {CNT_BITS{1'b0}};
`endif

endmodule

// File: tb/tb_surf_cmd_rx.sv
// Testbench for surf_cmd_rx: directed frames with a scoreboard of expected
// strobes (cycle, flags, buf/evid) popped by a monitor when a strobe appears.
module tb_surf_cmd_rx;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cmd_i = 1'b0;
  logic        enable_i = 1'b1;
  logic        evt_valid_o;
  logic [1:0]  buf_o;
  logic [31:0] evid_o;
  logic        parity_err_o;
  logic        frame_err_o;
  logic        busy_o;
  logic [15:0] good_cnt_o;
  logic [15:0] err_cnt_o;

`ifdef SURF_CMD_RX_COUNTERS_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  surf_cmd_rx dut (
    .clk_i(clk_i), .rst_i(rst_i), .cmd_i(cmd_i), .enable_i(enable_i),
    .evt_valid_o(evt_valid_o), .buf_o(buf_o), .evid_o(evid_o),
    .parity_err_o(parity_err_o), .frame_err_o(frame_err_o), .busy_o(busy_o),
    .good_cnt_o(good_cnt_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        v;
    logic        pe;
    logic        fe;
    logic [1:0]  b;
    logic [31:0] e;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_x;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [1:0]  m_buf = 2'd0;
  logic [31:0] m_evid = 32'd0;
  int          m_good = 0;
  int          m_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest scoreboard entry.
  always @(negedge clk_i) begin
    if ((evt_valid_o | parity_err_o | frame_err_o) === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_strobe", {61'd0, evt_valid_o, parity_err_o, frame_err_o}, 64'd0);
      end else begin
        mon_x = sb.pop_front();
        chk("strobe_cycle", 64'(cyc), 64'(mon_x.cyc));
        chk("evt_valid", 64'(evt_valid_o), 64'(mon_x.v));
        chk("parity_err", 64'(parity_err_o), 64'(mon_x.pe));
        chk("frame_err", 64'(frame_err_o), 64'(mon_x.fe));
        chk("strobe_buf", 64'(buf_o), 64'(mon_x.b));
        chk("strobe_evid", 64'(evid_o), 64'(mon_x.e));
      end
    end
  end

  task automatic send_frame(input logic [1:0] b, input logic [31:0] e,
                            input logic flip, input logic stop);
    logic [36:0] fr;
    logic        par;
    logic        good;
    exp_t        x;
    par = ~(^{b, e}) ^ flip;
    fr  = {1'b1, b, e, par, stop};
    for (int i = 36; i >= 0; i--) begin
      @(negedge clk_i);
      cmd_i = fr[i];
      if (i == 0) begin
        good = !stop && !flip;
        if (good) begin
          m_buf  = b;
          m_evid = e;
          m_good++;
        end else begin
          m_err++;
        end
        if ((good && enable_i) || flip || stop) begin
          x.cyc = cyc + 2;
          x.v   = good && enable_i;
          x.pe  = flip;
          x.fe  = stop;
          x.b   = m_buf;
          x.e   = m_evid;
          sb.push_back(x);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_i);
      cmd_i = 1'b0;
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_buf"}, 64'(buf_o), 64'(m_buf));
    chk({tag, "_evid"}, 64'(evid_o), 64'(m_evid));
    chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    chk({tag, "_good_cnt"}, 64'(good_cnt_o), CNT_ON ? 64'(m_good) : 64'd0);
    chk({tag, "_err_cnt"}, 64'(err_cnt_o), CNT_ON ? 64'(m_err) : 64'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_evt_valid", 64'(evt_valid_o), 64'd0);
    chk("rst_parity_err", 64'(parity_err_o), 64'd0);
    chk("rst_frame_err", 64'(frame_err_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    check_state("rst");

    // Basic good frame
    send_frame(2'b10, 32'hDEADBEEF, 1'b0, 1'b0);
    idle(5);
    check_state("good");

    // Back-to-back frames, zero idle
    send_frame(2'b01, 32'd1, 1'b0, 1'b0);
    send_frame(2'b11, 32'd2, 1'b0, 1'b0);
    idle(5);
    check_state("b2b");

    // Good frame then parity-flipped frame
    send_frame(2'b00, 32'd3, 1'b0, 1'b0);
    send_frame(2'b01, 32'd4, 1'b1, 1'b0);
    idle(5);
    check_state("parity");

    // Bad stop bit, line stuck high, then recovery
    send_frame(2'b10, 32'h11, 1'b0, 1'b1);
    repeat (50) begin
      @(negedge clk_i);
      cmd_i = 1'b1;
    end
    chk("stuck_busy", 64'(busy_o), 64'd1);
    idle(4);
    chk("stuck_released_busy", 64'(busy_o), 64'd0);
    check_state("stuck");
    send_frame(2'b11, 32'd5, 1'b0, 1'b0);
    idle(5);
    check_state("after_stuck");

    // Reset in the middle of a frame (after bit 20)
    begin
      logic [36:0] fr;
      fr = {1'b1, 2'b01, 32'hCAFE0123, 1'b0, 1'b0};
      for (int i = 36; i >= 16; i--) begin
        @(negedge clk_i);
        cmd_i = fr[i];
      end
    end
    chk("midframe_busy", 64'(busy_o), 64'd1);
    @(negedge clk_i);
    rst_i = 1'b1;
    cmd_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    m_buf = 2'd0;
    m_evid = 32'd0;
    m_good = 0;
    m_err = 0;
    chk("midrst_busy", 64'(busy_o), 64'd0);
    check_state("midrst");
    idle(40);
    check_state("midrst_quiet");
    send_frame(2'b10, 32'd7, 1'b0, 1'b0);
    idle(5);
    check_state("after_rst");

    // enable_i low: silent update
    enable_i = 1'b0;
    send_frame(2'b01, 32'd9, 1'b0, 1'b0);
    idle(5);
    check_state("disabled");
    enable_i = 1'b1;
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
